// File: rtl/sram_array_1r1w_init.sv
// 1R1W synchronous SRAM array with per-lane write mask, optional write-to-read
// forwarding and a zero-fill sweep after reset.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_INIT  | zero-filling ram[init_cnt] each cycle (or one-cycle pass-through
//          | when INIT_ON_RESET=0); requests ignored
// ST_READY | sweep complete, reads and writes accepted
module sram_array_1r1w_init #(
  parameter int DATA_WIDTH    = 148,
  parameter int DEPTH         = 32,
  parameter int MASK_GRAN     = 74,
  parameter int BYPASS        = 1,
  parameter int INIT_ON_RESET = 1,
  localparam int ADDR_WIDTH   = (DEPTH > 2) ? $clog2(DEPTH) : 1,
  localparam int LANES        = DATA_WIDTH / MASK_GRAN
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  R0_en,
  input  logic [ADDR_WIDTH-1:0] R0_addr,
  output logic [DATA_WIDTH-1:0] R0_data,
  output logic                  R0_valid,
  input  logic                  W0_en,
  input  logic [ADDR_WIDTH-1:0] W0_addr,
  input  logic [LANES-1:0]      W0_mask,
  input  logic [DATA_WIDTH-1:0] W0_data,
  output logic                  init_done
);

  if ((DATA_WIDTH % MASK_GRAN) != 0 || DEPTH < 2) begin : g_bad_params
    $error("sram_array_1r1w_init: DATA_WIDTH must be a multiple of MASK_GRAN and DEPTH >= 2");
  end

  typedef enum logic {ST_INIT, ST_READY} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   init_cnt;
  logic [DATA_WIDTH-1:0]   ram [DEPTH];
  logic                    ready;
  logic                    rd_in_range;
  logic                    wr_in_range;
  logic                    wr_ok;
  logic [DATA_WIDTH-1:0]   rd_word;

  assign ready       = (state == ST_READY);
  assign init_done   = ready;
  assign rd_in_range = ({1'b0, R0_addr} < DEPTH_W);
  assign wr_in_range = ({1'b0, W0_addr} < DEPTH_W);
  assign wr_ok       = ready && W0_en && wr_in_range;

  // Out-of-range reads return zeros; forwarding only ever applies to a live entry.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = ram[R0_addr];
      if (BYPASS != 0 && wr_ok && (W0_addr == R0_addr)) begin
        for (int i = 0; i < LANES; i++) begin
          if (W0_mask[i]) rd_word[i*MASK_GRAN +: MASK_GRAN] = W0_data[i*MASK_GRAN +: MASK_GRAN];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= ST_INIT;
      init_cnt <= '0;
      R0_data  <= '0;
      R0_valid <= 1'b0;
    end else begin
      R0_valid <= 1'b0;
      case (state)
        ST_INIT: begin
          if (INIT_ON_RESET == 0 || init_cnt == LAST_ADDR) state <= ST_READY;
          else init_cnt <= init_cnt + 1'b1;
        end
        ST_READY: begin
          if (R0_en) begin
            R0_data  <= rd_word;
            R0_valid <= 1'b1;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  // Storage has no reset of its own; only the sweep clears it.
  always_ff @(posedge clock) begin
    if (reset_n) begin
      if (state == ST_INIT && INIT_ON_RESET != 0) begin
        ram[init_cnt] <= '0;
      end else if (wr_ok) begin
        for (int i = 0; i < LANES; i++) begin
          if (W0_mask[i]) ram[W0_addr][i*MASK_GRAN +: MASK_GRAN] <= W0_data[i*MASK_GRAN +: MASK_GRAN];
        end
      end
    end
  end

endmodule

// File: doc/sram_array_1r1w_init.md
SRAM_ARRAY_1R1W_INIT -- requirements
Module: sram_array_1r1w_init

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 148, width of one array entry in bits.
REQ-002 SHALL provide parameter DEPTH, default 32, number of entries (any value >= 2, power of two not required).
REQ-003 SHALL provide parameter MASK_GRAN, default 74, bits per write-mask lane; DATA_WIDTH SHALL be an integer multiple of MASK_GRAN (elaboration error otherwise).
REQ-004 SHALL provide parameter BYPASS, default 1, 1 = same-cycle write-to-read forwarding, 0 = read returns pre-write contents.
REQ-005 SHALL provide parameter INIT_ON_RESET, default 1, 1 = zero-fill every entry after reset.
REQ-006 SHALL define derived ADDR_WIDTH = max(1, ceil(log2(DEPTH))) and LANES = DATA_WIDTH/MASK_GRAN.
REQ-007 clock  input  1  single clock; all state updates on rising edge.
REQ-008 reset_n  input  1  reset is synchronous and active-low.
REQ-009 R0_en  input  1  read request.
REQ-010 R0_addr  input  ADDR_WIDTH  read address.
REQ-011 R0_data  output  DATA_WIDTH  read data, registered.
REQ-012 R0_valid  output  1  one-cycle pulse, R0_data updated by an accepted read.
REQ-013 W0_en  input  1  write request.
REQ-014 W0_addr  input  ADDR_WIDTH  write address.
REQ-015 W0_mask  input  LANES  per-lane write enable; bit i covers data bits [i*MASK_GRAN +: MASK_GRAN].
REQ-016 W0_data  input  DATA_WIDTH  write data.
REQ-017 init_done  output  1  high when array accepts requests.

Function
REQ-018 SHALL implement an init FSM with states INIT and READY.
REQ-019 INIT: init counter starts at 0, writes all-zeros to ram[counter] each cycle, increments by 1; on the cycle counter == DEPTH-1 is written, FSM moves to READY next cycle.
REQ-020 With INIT_ON_RESET=0 the FSM SHALL enter READY on the first cycle after reset_n is sampled high, without writing the array.
REQ-021 init_done SHALL be 1 exactly when FSM is READY.
REQ-022 While not READY, R0_en and W0_en SHALL be ignored: no array write, R0_valid stays 0, R0_data holds.
REQ-023 Accepted read (R0_en=1, READY): R0_data and R0_valid=1 SHALL appear the following cycle (latency 1).
REQ-024 R0_data SHALL hold its last value when no read is accepted; R0_valid SHALL return to 0.
REQ-025 Accepted write (W0_en=1, READY) SHALL update only lanes with W0_mask[i]=1; other lanes keep prior contents; W0_mask=0 is a legal no-op.
REQ-026 Simultaneous read and write, different addresses: both proceed independently.
REQ-027 Same address, BYPASS=1: R0_data SHALL return W0_data for masked lanes and prior contents for unmasked lanes.
REQ-028 Same address, BYPASS=0: R0_data SHALL return full prior contents; write still takes effect.
REQ-029 Address >= DEPTH (non-power-of-two DEPTH): writes SHALL be dropped; reads SHALL return all-zeros with R0_valid=1.
REQ-030 No read-enable-gated address latch trickery: returned data SHALL correspond to array state at the read-accept edge (plus REQ-027 forwarding), independent of later writes.

Reset
REQ-031 While reset_n=0 at a rising edge: FSM <= INIT (or READY-pending when INIT_ON_RESET=0), counter <= 0, R0_data <= 0, R0_valid <= 0, init_done <= 0.
REQ-032 Reset asserted mid-init or mid-traffic SHALL abort any in-flight read (no R0_valid) and restart init from entry 0.
REQ-033 Array contents SHALL not be reset directly; only the init sweep clears them.

Verification
REQ-034 Defaults, release reset: init_done=0 for exactly 32 cycles, then 1; read every address -> 0 each, R0_valid one cycle after each R0_en.
REQ-035 Write addr 5 mask 2'b11 data D1, then write addr 5 mask 2'b01 data D2, read addr 5 -> upper 74 bits of D1, lower 74 bits of D2.
REQ-036 Same cycle write addr 9 mask 2'b10 data all-ones and read addr 9 (prior 0): BYPASS=1 -> upper lane ones, lower lane 0; BYPASS=0 -> all-zeros; subsequent read -> upper lane ones.
REQ-037 Assert reset_n=0 for 1 cycle at init counter 17 after writes done: init restarts, init_done low 32 more cycles, prior-written addresses read 0.
REQ-038 DEPTH=20, DATA_WIDTH=64, MASK_GRAN=8: write addr 25 -> dropped, read addr 25 -> 0 with R0_valid=1; init_done after 20 cycles.
REQ-039 R0_en and W0_en asserted during INIT -> no R0_valid, array content after init all-zeros.
